tpu_job_sequencer: RTL and testbench



---
 rtl/tpu_job_sequencer_if.sv | 37 +++
 rtl/tpu_job_sequencer.sv | 168 ++++++++++++++++
 tb/tb_tpu_job_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_job_sequencer_if.sv
// rtl/tpu_job_sequencer_if.sv - source fetch, result write and TPU bus signals of the job sequencer
interface tpu_job_sequencer_if #(
    parameter int DATAW  = 64,
    parameter int ADDRW  = 16,
    parameter int SRC_AW = 8
);
    logic              src_req;
    logic [SRC_AW-1:0] src_addr;
    logic              src_valid;
    logic [DATAW-1:0]  src_data;
    logic              res_we;
    logic [SRC_AW-1:0] res_addr;
    logic [DATAW-1:0]  res_data;
    logic              res_ready;
    logic              tpu_r_w;
    logic [ADDRW-1:0]  tpu_addr;
    logic [DATAW-1:0]  tpu_wdata;
    logic [DATAW-1:0]  tpu_rdata;

    modport master (
        output src_req, src_addr,
        input  src_valid, src_data,
        output res_we, res_addr, res_data,
        input  res_ready,
        output tpu_r_w, tpu_addr, tpu_wdata,
        input  tpu_rdata
    );

    modport slave (
        input  src_req, src_addr,
        output src_valid, src_data,
        input  res_we, res_addr, res_data,
        output res_ready,
        input  tpu_r_w, tpu_addr, tpu_wdata,
        output tpu_rdata
    );
endinterface

// File: rtl/tpu_job_sequencer.sv
// rtl/tpu_job_sequencer.sv - drives one matmul job: load A/B/C into the TPU, run it, copy C out
module tpu_job_sequencer #(
    parameter int DIM         = 8,
    parameter int DATAW       = 64,
    parameter int ADDRW       = 16,
    parameter int SRC_AW      = 8,
    parameter int MATMUL_WAIT = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_c,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [SRC_AW-1:0] res_base,
    output logic              busy,
    output logic              done,
    tpu_job_sequencer_if.master bus
);
    localparam int NWORDS = 4 * DIM;
    localparam int NRES   = 2 * DIM;
    localparam int KW     = $clog2(NWORDS);
    localparam int JW     = $clog2(NRES);
    localparam int WW     = (MATMUL_WAIT > 1) ? $clog2(MATMUL_WAIT) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_MM_GO   = 3'd3;
    localparam logic [2:0] S_MM_WAIT = 3'd4;
    localparam logic [2:0] S_READ    = 3'd5;
    localparam logic [2:0] S_PUSH    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]        state;
    logic [KW-1:0]     k_q;
    logic [JW-1:0]     j_q;
    logic [WW-1:0]     wait_q;
    logic [SRC_AW-1:0] src_base_q;
    logic [SRC_AW-1:0] res_base_q;
    logic              load_c_q;
    logic [DATAW-1:0]  data_q;
    logic [DATAW-1:0]  res_data_q;

    logic              k_last;
    logic              skip_next;
    logic              j_last;
    logic [ADDRW-1:0]  issue_addr;
    logic [ADDRW-1:0]  read_addr;

    assign k_last    = (32'(k_q) == NWORDS - 1);
    // C words are written as zeros without touching the source when load_c was low at start
    assign skip_next = !load_c_q && (32'(k_q) + 1 >= NRES);
    assign j_last    = (32'(j_q) == NRES - 1);
    assign read_addr = ADDRW'(32'h0300 + 32'(j_q) * 8);

    always_comb begin
        issue_addr = '0;
        if (32'(k_q) < DIM)
            issue_addr = ADDRW'(32'h0100 + 32'(k_q) * 8);
        else if (32'(k_q) < NRES)
            issue_addr = ADDRW'(32'h0200);
        else
            issue_addr = ADDRW'(32'h0300 + (32'(k_q) - NRES) * 8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            k_q        <= '0;
            j_q        <= '0;
            wait_q     <= '0;
            src_base_q <= '0;
            res_base_q <= '0;
            load_c_q   <= 1'b0;
            data_q     <= '0;
            res_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_base_q <= src_base;
                        res_base_q <= res_base;
                        load_c_q   <= load_c;
                        k_q        <= '0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.src_valid) begin
                        data_q <= bus.src_data;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    k_q <= k_q + 1'b1;
                    if (k_last) begin
                        state <= S_MM_GO;
                    end else if (skip_next) begin
                        data_q <= '0;
                        state  <= S_ISSUE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MM_GO: begin
                    wait_q <= '0;
                    j_q    <= '0;
                    state  <= (MATMUL_WAIT == 0) ? S_READ : S_MM_WAIT;
                end
                S_MM_WAIT: begin
                    if (32'(wait_q) == MATMUL_WAIT - 1)
                        state <= S_READ;
                    else
                        wait_q <= wait_q + 1'b1;
                end
                S_READ: begin
                    // dataOut is valid in the same cycle as the read address
                    res_data_q <= bus.tpu_rdata;
                    state      <= S_PUSH;
                end
                S_PUSH: begin
                    if (bus.res_ready) begin
                        j_q   <= j_q + 1'b1;
                        state <= j_last ? S_DONE : S_READ;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.src_req   = 1'b0;
        bus.src_addr  = '0;
        bus.res_we    = 1'b0;
        bus.res_addr  = '0;
        bus.tpu_r_w   = 1'b0;
        bus.tpu_addr  = '0;
        bus.tpu_wdata = '0;
        done          = 1'b0;
        busy          = (state != S_IDLE) && (state != S_DONE);
        case (state)
            S_FETCH: begin
                bus.src_req  = 1'b1;
                bus.src_addr = src_base_q + SRC_AW'(k_q);
            end
            S_ISSUE: begin
                bus.tpu_r_w   = 1'b1;
                bus.tpu_addr  = issue_addr;
                bus.tpu_wdata = data_q;
            end
            S_MM_GO: begin
                bus.tpu_r_w  = 1'b1;
                bus.tpu_addr = ADDRW'(32'h0400);
            end
            S_READ:  bus.tpu_addr = read_addr;
            S_PUSH: begin
                bus.res_we   = 1'b1;
                bus.res_addr = res_base_q + SRC_AW'(j_q);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign bus.res_data = res_data_q;
endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb/tb_tpu_job_sequencer.sv - directed jobs checked against a TPU/memory model every cycle
`timescale 1ns/1ps
module tb_tpu_job_sequencer;
    localparam int W0 = 26;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, load_c, sel;
    logic [7:0]  src_base, res_base;
    logic        busy0, done0, busy1, done1;
    logic        start0, start1;
    logic        src_valid, res_ready;
    logic [63:0] src_data, tpu_rdata;

    tpu_job_sequencer_if #(.DATAW(64), .ADDRW(16), .SRC_AW(8)) bus0 (), bus1 ();

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign bus0.src_valid = src_valid;
    assign bus0.src_data  = src_data;
    assign bus0.res_ready = res_ready;
    assign bus0.tpu_rdata = tpu_rdata;
    assign bus1.src_valid = src_valid;
    assign bus1.src_data  = src_data;
    assign bus1.res_ready = res_ready;
    assign bus1.tpu_rdata = tpu_rdata;

    tpu_job_sequencer #(.MATMUL_WAIT(W0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .load_c(load_c),
        .src_base(src_base), .res_base(res_base), .busy(busy0), .done(done0), .bus(bus0));

    tpu_job_sequencer #(.MATMUL_WAIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .load_c(load_c),
        .src_base(src_base), .res_base(res_base), .busy(busy1), .done(done1), .bus(bus1));

    logic        a_busy, a_done, a_src_req, a_res_we, a_tpu_r_w;
    logic [7:0]  a_src_addr, a_res_addr;
    logic [15:0] a_tpu_addr;
    logic [63:0] a_tpu_wdata, a_res_data;
    assign a_busy      = sel ? busy1 : busy0;
    assign a_done      = sel ? done1 : done0;
    assign a_src_req   = sel ? bus1.src_req : bus0.src_req;
    assign a_src_addr  = sel ? bus1.src_addr : bus0.src_addr;
    assign a_res_we    = sel ? bus1.res_we : bus0.res_we;
    assign a_res_addr  = sel ? bus1.res_addr : bus0.res_addr;
    assign a_res_data  = sel ? bus1.res_data : bus0.res_data;
    assign a_tpu_r_w   = sel ? bus1.tpu_r_w : bus0.tpu_r_w;
    assign a_tpu_addr  = sel ? bus1.tpu_addr : bus0.tpu_addr;
    assign a_tpu_wdata = sel ? bus1.tpu_wdata : bus0.tpu_wdata;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] src_mem [256];
    logic [63:0] res_mem [256];
    logic [63:0] tpu_a [8];
    logic [63:0] tpu_b [8];
    logic [63:0] tpu_c [16];
    logic [15:0] exp_addr [33];
    logic [63:0] exp_data [33];
    logic [15:0] obs_addr [33];

    int wi = 0, ri = 0, fi = 0, pi = 0, b_cnt = 0;
    int done_cnt = 0, cyc = 0, mm_cyc = 0, done_cyc = 0, fetch_max = 0, waitv = W0;
    int lat_lo = 1, lat_hi = 1, lat_tgt = 1, lat_cnt = 0, rr_mode = 0, t0 = 0;
    logic [7:0]  j_sbase = 8'h0, j_rbase = 8'h0;
    logic        j_loadc = 1'b1;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_addr = 8'h0;
    logic [63:0] prev_data = 64'h0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // TPU model: C += A x B with 8-bit elements and 16-bit accumulators, 4 lanes per C word
    function automatic void do_matmul();
        logic [15:0] acc;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                acc = tpu_c[2*r + c/4][16*(c%4) +: 16];
                for (int i = 0; i < 8; i++)
                    acc += 16'(tpu_a[r][8*i +: 8]) * 16'(tpu_b[i][8*c +: 8]);
                tpu_c[2*r + c/4][16*(c%4) +: 16] = acc;
            end
    endfunction

    function automatic logic [63:0] exp_word(input int j);
        logic [63:0] w;
        logic [15:0] acc;
        int r, c;
        r = j / 2;
        w = '0;
        for (int l = 0; l < 4; l++) begin
            c = 4 * (j % 2) + l;
            acc = j_loadc ? src_mem[8'(j_sbase + 16 + j)][16*l +: 16] : 16'h0;
            for (int i = 0; i < 8; i++)
                acc += 16'(src_mem[8'(j_sbase + r)][8*i +: 8]) * 16'(src_mem[8'(j_sbase + 8 + i)][8*c +: 8]);
            w[16*l +: 16] = acc;
        end
        return w;
    endfunction

    always_comb begin
        tpu_rdata = '0;
        if (!a_tpu_r_w && a_tpu_addr >= 16'h0300 && a_tpu_addr < 16'h0380)
            tpu_rdata = tpu_c[a_tpu_addr[6:3]];
    end

    always @(negedge clk) begin
        cyc++;
        if (a_src_req) begin
            if (lat_cnt >= lat_tgt) begin
                src_valid = 1'b1;
                src_data  = src_mem[a_src_addr];
            end else begin
                src_valid = 1'b0;
                src_data  = {$urandom(), $urandom()};
                lat_cnt++;
            end
        end else begin
            src_valid = 1'b0;
            lat_cnt   = 0;
        end
        res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? ($urandom_range(2, 0) != 0) : 1'b0;

        if (rst_n) begin
            if (a_tpu_r_w) begin
                if (wi < 33) begin
                    chk("tpu_write", {a_tpu_addr, a_tpu_wdata}, {exp_addr[wi], exp_data[wi]});
                    obs_addr[wi] = a_tpu_addr;
                    wi++;
                end else
                    chk("tpu_extra_write", {a_tpu_addr, a_tpu_wdata}, 80'h0);
                if (a_tpu_addr >= 16'h0100 && a_tpu_addr < 16'h0140)
                    tpu_a[a_tpu_addr[5:3]] = a_tpu_wdata;
                else if (a_tpu_addr == 16'h0200) begin
                    tpu_b[b_cnt[2:0]] = a_tpu_wdata;
                    b_cnt++;
                end else if (a_tpu_addr >= 16'h0300 && a_tpu_addr < 16'h0380)
                    tpu_c[a_tpu_addr[6:3]] = a_tpu_wdata;
                else if (a_tpu_addr == 16'h0400) begin
                    do_matmul();
                    mm_cyc = cyc;
                end
            end else begin
                chk("read_wdata_zero", a_tpu_wdata, 0);
                if (a_tpu_addr != 16'h0) begin
                    if (ri == 0) chk("mm_gap", cyc - mm_cyc, waitv + 1);
                    chk("tpu_read", {wi == 33, a_tpu_addr}, {1'b1, 16'(16'h0300 + 8 * ri)});
                    ri++;
                end
            end
            if (a_src_req) begin
                chk("src_addr", {fi < fetch_max, a_src_addr}, {1'b1, 8'(j_sbase + fi)});
                if (src_valid) begin
                    fi++;
                    lat_cnt = 0;
                    lat_tgt = $urandom_range(lat_hi, lat_lo);
                end
            end
            if (a_res_we) begin
                chk("res_addr", {pi < 16, a_res_addr}, {1'b1, 8'(j_rbase + pi)});
                chk("push_bus_idle", {a_tpu_r_w, a_tpu_addr}, 0);
                if (prev_stall) chk("res_hold", {a_res_addr, a_res_data}, {prev_addr, prev_data});
                if (res_ready) begin
                    res_mem[a_res_addr] = a_res_data;
                    pi++;
                end
                prev_stall = !res_ready;
                prev_addr  = a_res_addr;
                prev_data  = a_res_data;
            end else
                prev_stall = 1'b0;
            if (a_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", a_busy, 0);
            end
            if (a_tpu_r_w || a_src_req || a_res_we) chk("busy_active", a_busy, 1);
        end
    end

    task automatic fill_identity(input logic [7:0] sb, input logic [63:0] cfill);
        for (int r = 0; r < 8; r++) src_mem[8'(sb + r)] = 64'h1 << (8 * r);
        for (int i = 0; i < 8; i++) src_mem[8'(sb + 8 + i)] = 64'h0101010101010101 * (i + 1);
        for (int m = 0; m < 16; m++) src_mem[8'(sb + 16 + m)] = cfill;
    endtask

    task automatic fill_random(input logic [7:0] sb);
        for (int k = 0; k < 32; k++) src_mem[8'(sb + k)] = {$urandom(), $urandom()};
    endtask

    task automatic setup_job(input logic s, input logic [7:0] sb, input logic [7:0] rb, input logic lc,
                             input int llo, input int lhi, input int rrm);
        sel = s;
        waitv = s ? 0 : W0;
        j_sbase = sb; j_rbase = rb; j_loadc = lc;
        for (int k = 0; k < 32; k++) begin
            exp_addr[k] = (k < 8) ? 16'(16'h0100 + 8 * k) : (k < 16) ? 16'h0200 : 16'(16'h0300 + 8 * (k - 16));
            exp_data[k] = (k >= 16 && !lc) ? 64'h0 : src_mem[8'(sb + k)];
        end
        exp_addr[32] = 16'h0400;
        exp_data[32] = 64'h0;
        for (int a = 0; a < 256; a++) res_mem[a] = 64'hBAD0BAD0BAD0BAD0;
        wi = 0; ri = 0; fi = 0; pi = 0; b_cnt = 0; done_cnt = 0; prev_stall = 1'b0;
        fetch_max = lc ? 32 : 16;
        lat_lo = llo; lat_hi = lhi; lat_tgt = $urandom_range(lhi, llo);
        rr_mode = rrm;
        @(negedge clk); #1;
        start = 1'b1; load_c = lc; src_base = sb; res_base = rb; t0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_job(input int exp_lat);
        for (int t = 0; t < 3000 && done_cnt == 0; t++) @(negedge clk);
        if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("write_count", wi, 33);
        chk("fetch_count", fi, fetch_max);
        chk("push_count", pi, 16);
        if (exp_lat > 0) chk("latency", done_cyc - t0 + 1, exp_lat);
        for (int j = 0; j < 16; j++) chk("result", res_mem[8'(j_rbase + j)], exp_word(j));
    endtask

    initial begin
        start = 1'b0; load_c = 1'b0; sel = 1'b0; src_base = 8'h0; res_base = 8'h0;
        src_valid = 1'b0; res_ready = 1'b1; src_data = 64'h0;
        for (int a = 0; a < 256; a++) src_mem[a] = 64'h0;
        for (int i = 0; i < 16; i++) tpu_c[i] = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy0, done0, bus0.src_req, bus0.res_we, bus0.tpu_r_w}, 0);
        chk("rst_bus", {bus0.tpu_addr, bus0.tpu_wdata}, 0);
        chk("rst_addr", {bus0.src_addr, bus0.res_addr}, 0);
        chk("rst_res_data", bus0.res_data, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {busy0, bus0.src_req, bus0.tpu_r_w, bus0.tpu_addr}, 0);

        // identity A, B rows of constant 1..8, C = 0: product equals B
        fill_identity(8'h10, 64'h0);
        setup_job(1'b0, 8'h10, 8'h40, 1'b1, 1, 1, 0);
        finish_job(157);
        chk("res_row0_lo", res_mem[8'h40], 64'h0001000100010001);
        chk("res_row7_hi", res_mem[8'h4F], 64'h0008000800080008);
        chk("first_wr_addr", obs_addr[0], 16'h0100);
        chk("b_wr_addr", obs_addr[9], 16'h0200);
        chk("last_c_addr", obs_addr[31], 16'h0378);
        chk("matmul_addr", obs_addr[32], 16'h0400);

        // load_c=0: the nonzero C in source must never be fetched
        fill_identity(8'h10, 64'hFFFFFFFFFFFFFFFF);
        setup_job(1'b0, 8'h10, 8'h40, 1'b0, 1, 1, 0);
        finish_job(125);
        chk("noc_row3_hi", res_mem[8'h47], 64'h0004000400040004);

        // random operands, random source latency and result back-pressure
        fill_random(8'h20);
        setup_job(1'b0, 8'h20, 8'h80, 1'b1, 0, 5, 1);
        finish_job(0);

        // address wrap on both memories
        fill_random(8'hF0);
        setup_job(1'b0, 8'hF0, 8'hFC, 1'b1, 0, 2, 1);
        finish_job(0);

        // start during MM_WAIT is ignored; reset while stalled in PUSH
        fill_random(8'h30);
        setup_job(1'b0, 8'h30, 8'hA0, 1'b1, 1, 1, 2);
        for (int t = 0; t < 2000 && wi < 33; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        chk("busy_in_wait", busy0, 1);
        for (int t = 0; t < 200 && !a_res_we; t++) @(negedge clk);
        chk("reached_push", a_res_we, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {busy0, done0, bus0.src_req, bus0.res_we, bus0.tpu_r_w}, 0);
        chk("midrst_bus", {bus0.tpu_addr, bus0.tpu_wdata}, 0);
        chk("midrst_addr", {bus0.src_addr, bus0.res_addr}, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_after_rst", done_cnt, 0);
        fill_identity(8'h50, 64'h0003000300030003);
        setup_job(1'b0, 8'h50, 8'h60, 1'b1, 1, 1, 0);
        finish_job(157);
        chk("acc_row0_lo", res_mem[8'h60], 64'h0004000400040004);

        // zero MATMUL_WAIT instance: READ right after MM_GO
        fill_identity(8'h10, 64'h0);
        setup_job(1'b1, 8'h10, 8'h40, 1'b1, 1, 1, 0);
        finish_job(131);
        chk("w0_row0_lo", res_mem[8'h40], 64'h0001000100010001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
